if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Small in-order instruction buffer between the PC/instruction-memory fetch stage and the decode stage of the pipelined MIPS core.
- Each cycle the fetch stage offers one {pc, instr} pair; decode pops one pair when it is not stalled.
- Decouples decode stalls from PC advance.
- A redirect (taken branch/jump) drains the queue with a synchronous flush.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all entries this cycle (redirect)
- in_valid  input  1  fetch stage offers an entry
- in_ready  output  1  queue accepts an entry this cycle
- in_pc  input  32  PC of offered instruction
- in_instr  input  32  instruction word from IM
- out_valid  output  1  head entry present
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  32  head PC
- out_instr  output  32  head instruction
- out_exc  output  5  head exception code; 0 = none
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH registered entries of {pc[31:0], instr[31:0], exc[4:0]}.
  - rd_ptr and wr_ptr are PTR_W+1 bits; the MSB is the wrap bit.
  - empty = pointers equal; full = indices equal and wrap bits differ.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = ~full. It depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_valid = ~empty. The head entry is driven combinationally from storage (first-word fall-through).
- When empty, out_pc, out_instr and out_exc are forced to 0.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no same-cycle bypass.
- Full queue: push is blocked even if a pop occurs in the same cycle; in_ready recovers the cycle after the pop.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH on the index; the wrap bit toggles on each wrap.
- count = wr_ptr - rd_ptr, computed at PTR_W+1 bits.
- flush: at the next edge rd_ptr <= 0, wr_ptr <= 0, count = 0.
  - Any push or pop in the flush cycle is ignored.
  - Entry contents need not be cleared; output masking hides them.
- reset:
  - Takes priority over flush.
  - Pointers go to 0 and all entries are cleared to 0.
  - After reset: out_valid=0, in_ready=1, count=0, out_pc/out_instr/out_exc=0.
  - Reset mid-operation discards all contents.
- No state machine beyond the pointer pair. Occupancy fully defines the state: EMPTY, PARTIAL or FULL.

Optional Feature:
- Macro: FETCH_EXC_CHECK_EN
- Defined: each pushed entry is checked on entry.
  - AdEL fault if in_pc[1:0] != 0 or in_pc is outside 32'h0000_3000..32'h0000_6FFC inclusive.
  - On fault, store exc=5'd4 (AdEL) and instr=32'h0000_0000 (nop); pc is stored unchanged.
  - Otherwise store exc=0.
- Undefined: exc is always stored as 0 and instr is stored unchanged. The out_exc port remains and reads 0.

Decomposition:
- Shared package/header:
  - PC_INIT (32'h0000_3000), IM_LO (32'h0000_3000), IM_HI (32'h0000_6FFC).
  - EXC_NONE (5'd0), EXC_ADEL (5'd4).
  - Fetch-entry typedef {pc, instr, exc}.
- Natural sub-module: fetch_addr_check. It is combinational, takes pc in and gives exc_code/fault out, and is instantiated only under FETCH_EXC_CHECK_EN.

Test Plan:
- Reset, then push 4 entries pc=3000/3004/3008/300C with out_ready=0 -> count=4, in_ready=0. A fifth push of pc=3010 is dropped; count stays 4.
- Then out_ready=1 for 4 cycles -> out_pc in order 3000, 3004, 3008, 300C; count=0 and out_valid=0 after the last pop.
- At count=2, hold in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, order is preserved across a pointer wrap, nothing lost or duplicated.
- At count=3, assert flush with in_valid=1 (pc=4000) -> next cycle count=0, out_valid=0, out_pc=0. Entry 4000 is absent afterwards.
- At count=2, assert reset with flush and in_valid -> next cycle count=0, in_ready=1, all outputs 0.
- Feature on: push pc=3002 -> out_exc=4, out_instr=0. Push pc=7000 -> out_exc=4. Push pc=6FFC with instr=0x2408_0001 -> out_exc=0, instr unchanged.
- Feature off: the same pushes give out_exc=0 with instructions unchanged.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants and entry type for the fetch queue
package if_fetch_queue_pkg;

  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } fetch_entry_t;

  // Word-aligned and inside the instruction memory window.
  function automatic logic pc_is_fetchable(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= IM_LO) && (pc <= IM_HI);
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - combinational AdEL check on a fetch PC
module fetch_addr_check
  import if_fetch_queue_pkg::*;
(
  input  logic [31:0] pc,
  output logic [4:0]  exc_code,
  output logic        fault
);

  always_comb begin
    fault    = ~pc_is_fetchable(pc);
    exc_code = fault ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - in-order fetch-to-decode buffer; FETCH_EXC_CHECK_EN enables AdEL tagging on entry
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [4:0]       out_exc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  fetch_entry_t mem [DEPTH];
  fetch_entry_t new_entry;
  fetch_entry_t head;

  logic [PTR_W:0]   rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_idx, wr_idx;
  logic             empty, full, push, pop;

  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign wr_idx = wr_ptr[PTR_W-1:0];

  // Wrap bits disambiguate full from empty when the indices match.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_idx == wr_idx) && (rd_ptr[PTR_W] != wr_ptr[PTR_W]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = wr_ptr - rd_ptr;

`ifdef FETCH_EXC_CHECK_EN
  logic [4:0] chk_exc;
  logic       chk_fault;

  fetch_addr_check u_addr_check (
    .pc       (in_pc),
    .exc_code (chk_exc),
    .fault    (chk_fault)
  );

  // A faulting fetch is turned into a nop so decode never acts on garbage.
  always_comb begin
    new_entry.pc    = in_pc;
    new_entry.instr = chk_fault ? INSTR_NOP : in_instr;
    new_entry.exc   = chk_exc;
  end
`else
  always_comb begin
    new_entry.pc    = in_pc;
    new_entry.instr = in_instr;
    new_entry.exc   = EXC_NONE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Stale entries stay in storage after a flush; masking hides them.
  always_comb begin
    head      = mem[rd_idx];
    out_pc    = empty ? 32'h0 : head.pc;
    out_instr = empty ? 32'h0 : head.instr;
    out_exc   = empty ? EXC_NONE : head.exc;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue (expectations follow FETCH_EXC_CHECK_EN)
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_exc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  fetch_entry_t sb[$];

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t model_entry(input logic [31:0] pc, input logic [31:0] instr);
    fetch_entry_t e;
    e.pc = pc;
`ifdef FETCH_EXC_CHECK_EN
    if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFC) begin
      e.instr = 32'h0;
      e.exc   = 5'd4;
    end else begin
      e.instr = instr;
      e.exc   = 5'd0;
    end
`else
    e.instr = instr;
    e.exc   = 5'd0;
`endif
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
  endtask

  // Compare outputs against the scoreboard, then advance model and DUT one edge.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    check("count", 32'(count), 32'(sb.size()));
    check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() == 0) begin
      check("out_pc_masked", out_pc, 32'h0);
      check("out_instr_masked", out_instr, 32'h0);
      check("out_exc_masked", 32'(out_exc), 32'h0);
    end else begin
      check("out_pc", out_pc, sb[0].pc);
      check("out_instr", out_instr, sb[0].instr);
      check("out_exc", 32'(out_exc), 32'(sb[0].exc));
    end
    if (reset || flush) begin
      sb.delete();
    end else begin
      do_push = in_valid && (sb.size() < DEPTH);
      do_pop  = out_ready && (sb.size() > 0);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(model_entry(in_pc, in_instr));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;

    // Fill to full; fifth push is dropped.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0);
      cycle();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 32'h3010, 32'hDEAD_0000, 1'b0);
    cycle();
    check("drop_count", 32'(count), 32'd4);

    // Full with simultaneous pop: push still blocked.
    drive(1'b1, 32'h3010, 32'hDEAD_0001, 1'b1);
    cycle();
    check("full_pop_count", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (3) cycle();
    check("drained_count", 32'(count), 32'd0);
    check("drained_valid", 32'(out_valid), 32'h0);

    // Steady state at count=2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h3100 + 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h3200 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1'b1);
      cycle();
      check("steady_count", 32'(count), 32'd2);
    end

    // Grow to 3, then flush with a concurrent push.
    drive(1'b1, 32'h3300, 32'h4000_0000, 1'b0);
    cycle();
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'h4000, 32'h4444_4444, 1'b1);
    cycle();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_pc", out_pc, 32'h0);
    drive(1'b1, 32'h5000, 32'h5555_5555, 1'b0);
    cycle();
    check("post_flush_head", out_pc, 32'h5000);

    // Reset with flush and push at count=2.
    drive(1'b1, 32'h5004, 32'h5555_5556, 1'b0);
    cycle();
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h5008, 32'h5555_5557, 1'b0);
    cycle();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_mid_count", 32'(count), 32'h0);
    check("rst_mid_in_ready", 32'(in_ready), 32'h1);
    check("rst_mid_out_instr", out_instr, 32'h0);
    cycle();

    // Address checking cases, one at a time through an empty queue.
    drive(1'b1, 32'h3002, 32'h2408_0001, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
`ifdef FETCH_EXC_CHECK_EN
    check("misaligned_exc", 32'(out_exc), 32'd4);
    check("misaligned_instr", out_instr, 32'h0);
`else
    check("misaligned_exc", 32'(out_exc), 32'd0);
    check("misaligned_instr", out_instr, 32'h2408_0001);
`endif
    cycle();
    drive(1'b1, 32'h7000, 32'h2408_0002, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
`ifdef FETCH_EXC_CHECK_EN
    check("range_exc", 32'(out_exc), 32'd4);
`else
    check("range_exc", 32'(out_exc), 32'd0);
`endif
    cycle();
    drive(1'b1, 32'h6FFC, 32'h2408_0001, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("top_word_exc", 32'(out_exc), 32'd0);
    check("top_word_instr", out_instr, 32'h2408_0001);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
